// File: rtl/axi_mmio_pkg.sv
// Shared constants, register offsets, FSM state types and small helpers
// for the AXI memory-mapped peripheral register block.
package axi_mmio_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int unsigned OFF_SCRATCH  = 'h00;
   localparam int unsigned OFF_GPIO_OUT = 'h04;
   localparam int unsigned OFF_GPIO_IN  = 'h08;
   localparam int unsigned OFF_TIME_LO  = 'h0C;
   localparam int unsigned OFF_TIME_HI  = 'h10;
   localparam int unsigned OFF_ID       = 'h14;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
   typedef enum logic {R_IDLE, R_DATA} rState_e;

   typedef enum logic [2:0] {
      SEL_SCRATCH, SEL_GPIO_OUT, SEL_GPIO_IN, SEL_TIME_LO, SEL_TIME_HI, SEL_ID, SEL_NONE
   } regSel_e;

   function automatic logic [31:0] mergeStrb(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
      logic [31:0] res;
      res = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
      end
      return res;
   endfunction

   // WRAP and the reserved encoding are rejected beat by beat.
   function automatic logic burstSupported(input logic [1:0] burst);
      return (burst == BURST_FIXED) || (burst == BURST_INCR);
   endfunction

endpackage

// File: rtl/axi_mmio_burst_addr.sv
// Next word address and beat counter for one AXI burst; instantiated once
// per channel. Addresses are word indices, so wrap is modulo 2^ADDR_WIDTH bytes.
module axi_mmio_burst_addr
   import axi_mmio_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic [ADDR_WIDTH-3:0] word,
   input  logic [1:0]            burst,
   input  logic [7:0]            len,
   input  logic [7:0]            beatCnt,
   output logic [ADDR_WIDTH-3:0] nextWord,
   output logic [7:0]            nextCnt,
   output logic                  lastBeat,
   output logic                  burstOk
);

   assign burstOk  = burstSupported(burst);
   assign nextWord = (burst == BURST_INCR) ? word + 1'b1 : word;
   assign nextCnt  = beatCnt + 8'd1;
   assign lastBeat = (beatCnt == len);

endmodule

// File: rtl/axi_mmio_regs.sv
// AXI4 responder exposing scratch, GPIO, a 64-bit cycle timer with a coherent
// high-word shadow, and a constant ID register. Read and write run independently.
module axi_mmio_regs
   import axi_mmio_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter int          ID_WIDTH   = 1,
   parameter int          GPIO_WIDTH = 8,
   parameter logic [31:0] ID_VALUE   = 32'h5643_0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   input  logic [GPIO_WIDTH-1:0] gpio_in
);

   typedef logic [ADDR_WIDTH-3:0] wordOff_t;

   function automatic regSel_e decode(input wordOff_t off);
      regSel_e sel;
      sel = SEL_NONE;
      if (off == wordOff_t'(OFF_SCRATCH / 4))  sel = SEL_SCRATCH;
      if (off == wordOff_t'(OFF_GPIO_OUT / 4)) sel = SEL_GPIO_OUT;
      if (off == wordOff_t'(OFF_GPIO_IN / 4))  sel = SEL_GPIO_IN;
      if (off == wordOff_t'(OFF_TIME_LO / 4))  sel = SEL_TIME_LO;
      if (off == wordOff_t'(OFF_TIME_HI / 4))  sel = SEL_TIME_HI;
      if (off == wordOff_t'(OFF_ID / 4))       sel = SEL_ID;
      return sel;
   endfunction

   // Size fields and sub-word address bits carry no information for 32-bit registers.
   logic unusedOk;
   assign unusedOk = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   logic [31:0]           scratch;
   logic [63:0]           timer;
   logic [31:0]           timeHiShadow;
   logic [GPIO_WIDTH-1:0] gpioSync1, gpioSync2;
   logic [31:0]           gpioOutExt, gpioInExt;

   wState_e               wState;
   wordOff_t              wWord, wNextWord;
   logic [1:0]            wBurst;
   logic [7:0]            wLen, wCnt, wNextCnt;
   logic                  wLastBeat, wBurstOk, wErr;
   regSel_e               wSel;
   logic                  wFire, wWritable, beatErr;

   rState_e               rState;
   wordOff_t              rWord, rNextWord;
   logic [1:0]            rBurst;
   logic [7:0]            rLen, rCnt, rNextCnt;
   logic                  rLastBeat, rBurstOk;

   wordOff_t              beatWord;
   regSel_e               beatSel;
   logic                  beatBurstOk, beatLast, beatLoad, shadowLoad;
   logic [31:0]           beatData;
   logic [1:0]            beatResp;

   axi_mmio_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) uWrAddr (
      .word(wWord), .burst(wBurst), .len(wLen), .beatCnt(wCnt),
      .nextWord(wNextWord), .nextCnt(wNextCnt), .lastBeat(wLastBeat), .burstOk(wBurstOk)
   );

   axi_mmio_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) uRdAddr (
      .word(rWord), .burst(rBurst), .len(rLen), .beatCnt(rCnt),
      .nextWord(rNextWord), .nextCnt(rNextCnt), .lastBeat(rLastBeat), .burstOk(rBurstOk)
   );

   always_comb begin
      gpioOutExt = '0;
      gpioOutExt[GPIO_WIDTH-1:0] = gpio_out;
      gpioInExt = '0;
      gpioInExt[GPIO_WIDTH-1:0] = gpioSync2;
   end

   assign wFire     = (wState == W_DATA) && s_axi_wvalid;
   assign wSel      = decode(wWord);
   assign wWritable = wBurstOk && ((wSel == SEL_SCRATCH) || (wSel == SEL_GPIO_OUT));
   assign beatErr   = !wWritable || (s_axi_wlast != wLastBeat);

   // The first beat is decoded straight from the AR channel to get one-cycle latency.
   always_comb begin
      if (rState == R_IDLE) begin
         beatWord    = s_axi_araddr[ADDR_WIDTH-1:2];
         beatBurstOk = burstSupported(s_axi_arburst);
         beatLast    = (s_axi_arlen == 8'd0);
      end else begin
         beatWord    = rNextWord;
         beatBurstOk = rBurstOk;
         beatLast    = (rNextCnt == rLen);
      end
      beatSel  = decode(beatWord);
      beatData = '0;
      beatResp = RESP_OKAY;
      if (!beatBurstOk) begin
         beatResp = RESP_SLVERR;
      end else begin
         case (beatSel)
            SEL_SCRATCH:  beatData = scratch;
            SEL_GPIO_OUT: beatData = gpioOutExt;
            SEL_GPIO_IN:  beatData = gpioInExt;
            SEL_TIME_LO:  beatData = timer[31:0];
            SEL_TIME_HI:  beatData = timeHiShadow;
            SEL_ID:       beatData = ID_VALUE;
            default:      beatResp = RESP_SLVERR;
         endcase
      end
   end

   assign beatLoad   = ((rState == R_IDLE) && s_axi_arready && s_axi_arvalid) ||
                       ((rState == R_DATA) && s_axi_rready && !rLastBeat);
   assign shadowLoad = beatLoad && beatBurstOk && (beatSel == SEL_TIME_LO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer     <= '0;
         gpioSync1 <= '0;
         gpioSync2 <= '0;
      end else begin
         timer     <= timer + 64'd1;
         gpioSync1 <= gpio_in;
         gpioSync2 <= gpioSync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch  <= '0;
         gpio_out <= '0;
      end else if (wFire && wWritable) begin
         if (wSel == SEL_SCRATCH)
            scratch <= mergeStrb(scratch, s_axi_wdata, s_axi_wstrb);
         else
            gpio_out <= GPIO_WIDTH'(mergeStrb(gpioOutExt, s_axi_wdata, s_axi_wstrb));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wState        <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_bid     <= '0;
         wWord         <= '0;
         wBurst        <= BURST_FIXED;
         wLen          <= 8'd0;
         wCnt          <= 8'd0;
         wErr          <= 1'b0;
      end else begin
         case (wState)
            W_IDLE: begin
               if (!s_axi_awready) begin
                  s_axi_awready <= 1'b1;
               end else if (s_axi_awvalid) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  s_axi_bid     <= s_axi_awid;
                  wWord         <= s_axi_awaddr[ADDR_WIDTH-1:2];
                  wBurst        <= s_axi_awburst;
                  wLen          <= s_axi_awlen;
                  wCnt          <= 8'd0;
                  wErr          <= 1'b0;
                  wState        <= W_DATA;
               end
            end
            W_DATA: begin
               if (s_axi_wvalid) begin
                  // Beat count, not wlast, ends the burst; a wlast mismatch only taints bresp.
                  if (wLastBeat) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (wErr || beatErr) ? RESP_SLVERR : RESP_OKAY;
                     wState       <= W_RESP;
                  end else begin
                     wWord <= wNextWord;
                     wCnt  <= wNextCnt;
                     wErr  <= wErr || beatErr;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  wState        <= W_IDLE;
               end
            end
            default: wState <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rState        <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rlast   <= 1'b0;
         s_axi_rid     <= '0;
         rWord         <= '0;
         rBurst        <= BURST_FIXED;
         rLen          <= 8'd0;
         rCnt          <= 8'd0;
         timeHiShadow  <= '0;
      end else begin
         if (shadowLoad) timeHiShadow <= timer[63:32];
         case (rState)
            R_IDLE: begin
               if (!s_axi_arready) begin
                  s_axi_arready <= 1'b1;
               end else if (s_axi_arvalid) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rid     <= s_axi_arid;
                  rWord         <= s_axi_araddr[ADDR_WIDTH-1:2];
                  rBurst        <= s_axi_arburst;
                  rLen          <= s_axi_arlen;
                  rCnt          <= 8'd0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rdata   <= beatData;
                  s_axi_rresp   <= beatResp;
                  s_axi_rlast   <= beatLast;
                  rState        <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  if (rLastBeat) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     rState        <= R_IDLE;
                  end else begin
                     rWord       <= rNextWord;
                     rCnt        <= rNextCnt;
                     s_axi_rdata <= beatData;
                     s_axi_rresp <= beatResp;
                     s_axi_rlast <= beatLast;
                  end
               end
            end
            default: rState <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mmio_regs.sv
// Directed bench for axi_mmio_regs: register access, bursts, timer coherence,
// error responses and asynchronous reset, all against hand-computed values.
module tb_axi_mmio_regs;
   import axi_mmio_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
   logic [11:0] s_axi_awaddr, s_axi_araddr;
   logic [7:0]  s_axi_awlen, s_axi_arlen;
   logic [2:0]  s_axi_awsize, s_axi_arsize;
   logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_wdata, s_axi_rdata;
   logic [3:0]  s_axi_wstrb;
   logic [7:0]  gpio_out, gpio_in;

   int checks = 0;
   int errors = 0;

   axi_mmio_regs dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .gpio_out(gpio_out), .gpio_in(gpio_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic awSend(input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [0:0] id);
      logic done;
      done = 1'b0;
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
      s_axi_awburst = burst; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         if (s_axi_awready) done = 1'b1;
         tick();
      end
      s_axi_awvalid = 1'b0;
      chk("aw_handshake", 32'(done), 1);
   endtask

   task automatic wSend(input logic [31:0] data, input logic [3:0] strb, input logic last);
      logic done;
      done = 1'b0;
      s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         if (s_axi_wready) done = 1'b1;
         tick();
      end
      s_axi_wvalid = 1'b0;
      chk("w_handshake", 32'(done), 1);
   endtask

   task automatic bRecv(output logic [1:0] resp, output logic [0:0] id);
      logic done;
      done = 1'b0; resp = 2'b11; id = 1'b0;
      s_axi_bready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         if (s_axi_bvalid) begin
            resp = s_axi_bresp; id = s_axi_bid; done = 1'b1;
         end
         tick();
      end
      s_axi_bready = 1'b0;
      chk("b_handshake", 32'(done), 1);
   endtask

   task automatic arSend(input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [0:0] id);
      logic done;
      done = 1'b0;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arburst = burst; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         if (s_axi_arready) done = 1'b1;
         tick();
      end
      s_axi_arvalid = 1'b0;
      chk("ar_handshake", 32'(done), 1);
   endtask

   task automatic rRecv(output logic [31:0] data, output logic [1:0] resp, output logic last);
      logic done;
      done = 1'b0; data = '0; resp = 2'b11; last = 1'b0;
      s_axi_rready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         if (s_axi_rvalid) begin
            data = s_axi_rdata; resp = s_axi_rresp; last = s_axi_rlast; done = 1'b1;
         end
         tick();
      end
      s_axi_rready = 1'b0;
      chk("r_handshake", 32'(done), 1);
   endtask

   task automatic readWord(input logic [11:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      logic last;
      arSend(addr, 8'd0, BURST_INCR, 1'b0);
      rRecv(data, resp, last);
      chk("single_rlast", 32'(last), 1);
   endtask

   logic [31:0] rd, lo, hi, prevData;
   logic [1:0]  resp;
   logic [0:0]  bidSeen;
   logic        last, prevLast, stalled;
   logic [31:0] got[4];
   logic        lastSeen[4];
   int          beats;

   initial begin
      s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
      s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      gpio_in = 8'h5A;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 32'(s_axi_awready), 0);
      chk("rst_arready", 32'(s_axi_arready), 0);
      chk("rst_wready", 32'(s_axi_wready), 0);
      chk("rst_bvalid", 32'(s_axi_bvalid), 0);
      chk("rst_rvalid", 32'(s_axi_rvalid), 0);
      chk("rst_rdata", s_axi_rdata, 0);
      chk("rst_gpio_out", 32'(gpio_out), 0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_awready", 32'(s_axi_awready), 1);
      chk("post_rst_arready", 32'(s_axi_arready), 1);

      // Single write then read of SCRATCH
      awSend(12'h000, 8'd0, BURST_INCR, 1'b1);
      wSend(32'hDEADBEEF, 4'hF, 1'b1);
      bRecv(resp, bidSeen);
      chk("wr1_bresp", 32'(resp), 0);
      chk("wr1_bid", 32'(bidSeen), 1);
      arSend(12'h000, 8'd0, BURST_INCR, 1'b1);
      chk("rd1_latency_rvalid", 32'(s_axi_rvalid), 1);
      chk("rd1_rid", 32'(s_axi_rid), 1);
      rRecv(rd, resp, last);
      chk("rd1_rdata", rd, 32'hDEADBEEF);
      chk("rd1_rresp", 32'(resp), 0);
      chk("rd1_rlast", 32'(last), 1);

      // INCR write burst across SCRATCH and GPIO_OUT
      awSend(12'h000, 8'd1, BURST_INCR, 1'b0);
      wSend(32'h11223344, 4'hF, 1'b0);
      wSend(32'h000000A5, 4'h1, 1'b1);
      bRecv(resp, bidSeen);
      chk("incr_bresp", 32'(resp), 0);
      chk("incr_gpio_out", 32'(gpio_out), 32'hA5);
      tick();
      chk("incr_single_b", 32'(s_axi_bvalid), 0);
      readWord(12'h000, rd, resp);
      chk("incr_scratch", rd, 32'h11223344);

      // Byte strobes: bytes 0 and 2 replaced
      awSend(12'h000, 8'd0, BURST_INCR, 1'b0);
      wSend(32'hAABBCCDD, 4'b0101, 1'b1);
      bRecv(resp, bidSeen);
      readWord(12'h000, rd, resp);
      chk("strb_scratch", rd, 32'h11BB33DD);

      // GPIO_OUT keeps only its low bits
      awSend(12'h004, 8'd0, BURST_INCR, 1'b0);
      wSend(32'hFFFFFFFF, 4'hF, 1'b1);
      bRecv(resp, bidSeen);
      chk("gpio_out_ff", 32'(gpio_out), 32'hFF);
      readWord(12'h004, rd, resp);
      chk("gpio_out_read", rd, 32'h000000FF);

      // WRAP write is rejected and discarded
      awSend(12'h000, 8'd0, BURST_WRAP, 1'b0);
      wSend(32'h12345678, 4'hF, 1'b1);
      bRecv(resp, bidSeen);
      chk("wrap_wr_bresp", 32'(resp), 2);
      readWord(12'h000, rd, resp);
      chk("wrap_wr_scratch", rd, 32'h11BB33DD);

      // RO write and unmapped read
      awSend(12'h014, 8'd0, BURST_INCR, 1'b1);
      wSend(32'h0BADF00D, 4'hF, 1'b1);
      bRecv(resp, bidSeen);
      chk("ro_wr_bresp", 32'(resp), 2);
      chk("ro_wr_bid", 32'(bidSeen), 1);
      readWord(12'h014, rd, resp);
      chk("id_value", rd, 32'h56430001);
      chk("id_rresp", 32'(resp), 0);
      readWord(12'h040, rd, resp);
      chk("unmapped_rdata", rd, 0);
      chk("unmapped_rresp", 32'(resp), 2);

      // Timer high word stays coherent across a 2^32 crossing
      force dut.timer = 64'h0000_0000_FFFF_FFE0;
      tick();
      release dut.timer;
      readWord(12'h00C, lo, resp);
      chk("time_lo_near_wrap", 32'(lo[31:5]), 32'h07FFFFFF);
      repeat (40) tick();
      readWord(12'h010, hi, resp);
      chk("time_hi_coherent", hi, 0);
      readWord(12'h00C, lo, resp);
      readWord(12'h010, hi, resp);
      chk("time_hi_after_cross", hi, 1);

      // INCR len 3 read with rready toggling 1,0,1,0
      arSend(12'h008, 8'd3, BURST_INCR, 1'b1);
      chk("burst_latency_rvalid", 32'(s_axi_rvalid), 1);
      beats = 0; stalled = 1'b0; prevData = '0; prevLast = 1'b0;
      for (int c = 0; c < 16 && beats < 4; c++) begin
         s_axi_rready = (c % 2 == 0);
         if (stalled) begin
            chk("stall_rdata", s_axi_rdata, prevData);
            chk("stall_rlast", 32'(s_axi_rlast), 32'(prevLast));
         end
         if (s_axi_rvalid && s_axi_rready) begin
            got[beats] = s_axi_rdata; lastSeen[beats] = s_axi_rlast;
            beats++; stalled = 1'b0;
         end else begin
            stalled = s_axi_rvalid; prevData = s_axi_rdata; prevLast = s_axi_rlast;
         end
         tick();
      end
      s_axi_rready = 1'b0;
      chk("burst_beats", 32'(beats), 4);
      chk("burst_gpio_in", got[0], 32'h5A);
      chk("burst_time_hi", got[2], 1);
      chk("burst_id", got[3], 32'h56430001);
      chk("burst_rlast0", 32'(lastSeen[0]), 0);
      chk("burst_rlast1", 32'(lastSeen[1]), 0);
      chk("burst_rlast2", 32'(lastSeen[2]), 0);
      chk("burst_rlast3", 32'(lastSeen[3]), 1);
      chk("burst_done_rvalid", 32'(s_axi_rvalid), 0);

      // WRAP read: every beat SLVERR with zero data
      arSend(12'h000, 8'd1, BURST_WRAP, 1'b0);
      rRecv(rd, resp, last);
      chk("wrap_rd0_data", rd, 0);
      chk("wrap_rd0_resp", 32'(resp), 2);
      chk("wrap_rd0_last", 32'(last), 0);
      rRecv(rd, resp, last);
      chk("wrap_rd1_resp", 32'(resp), 2);
      chk("wrap_rd1_last", 32'(last), 1);

      // Early wlast: beat count still governs, response is SLVERR
      awSend(12'h000, 8'd2, BURST_FIXED, 1'b0);
      wSend(32'h1, 4'hF, 1'b0);
      wSend(32'h2, 4'hF, 1'b1);
      chk("early_wlast_no_b", 32'(s_axi_bvalid), 0);
      wSend(32'h3, 4'hF, 1'b0);
      bRecv(resp, bidSeen);
      chk("early_wlast_bresp", 32'(resp), 2);

      // Reset mid read burst
      arSend(12'h000, 8'd3, BURST_INCR, 1'b0);
      chk("abort_rvalid_before", 32'(s_axi_rvalid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_rvalid_async", 32'(s_axi_rvalid), 0);
      chk("abort_arready", 32'(s_axi_arready), 0);
      chk("abort_gpio_out", 32'(gpio_out), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("abort_arready_after", 32'(s_axi_arready), 1);
      chk("abort_awready_after", 32'(s_axi_awready), 1);
      chk("abort_no_rvalid", 32'(s_axi_rvalid), 0);
      readWord(12'h000, rd, resp);
      chk("abort_scratch_reset", rd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
